// File: rtl/bullet_pool_pkg.sv
// Shared definitions for the bullet pool: direction codes, default screen
// limits, plot colour selects and the plot sequencer state type.
package bullet_pool_pkg;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;

  localparam int SCREEN_X_MAX = 139;
  localparam int SCREEN_Y_MAX = 119;

  // plot_erase value: background colour wipes the old pixel, bullet colour draws
  localparam logic PLOT_COLOUR_BG     = 1'b1;
  localparam logic PLOT_COLOUR_BULLET = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ERASE,
    ST_DRAW,
    ST_NEXT
  } plot_state_t;

endpackage

// File: rtl/bullet_pool_slot.sv
// One projectile slot: live flag, position, previous position and heading.
// Ports:
//   clk, resetn          clock, async active-low reset
//   load                 take a new bullet from load_* (slot is free)
//   step                 movement tick; moves the bullet if live
//   kill                 collision; clears a live slot, beats load and step
//   load_x/y, load_dir_* spawn position and heading
//   active               slot is live
//   pos_x/y              current position (drawn)
//   old_x/y              position before the last step (erased)
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = SCREEN_X_MAX,
  parameter int Y_MAX = SCREEN_Y_MAX,
  parameter int STEP  = 3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           step,
  input  logic           kill,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic [1:0]     load_dir_x,
  input  logic [1:0]     load_dir_y,
  output logic           active,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [X_W-1:0] old_x,
  output logic [Y_W-1:0] old_y
);

  localparam logic signed [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic signed [Y_W:0] STEP_Y = (Y_W+1)'(STEP);
  localparam logic signed [X_W:0] LIM_X  = (X_W+1)'(X_MAX);
  localparam logic signed [Y_W:0] LIM_Y  = (Y_W+1)'(Y_MAX);

  logic [1:0]            dir_x, dir_y;
  logic signed [X_W:0]   delta_x, next_x;
  logic signed [Y_W:0]   delta_y, next_y;
  logic                  retire;

  // One extra sign bit lets a step below zero show up as negative.
  always_comb begin
    delta_x = '0;
    delta_y = '0;
    case (dir_x)
      DIR_POS:  delta_x = STEP_X;
      DIR_NEG:  delta_x = -STEP_X;
      DIR_HOLD: delta_x = '0;
      default:  delta_x = '0;
    endcase
    // screen y grows downwards, so "up" subtracts
    case (dir_y)
      DIR_POS:  delta_y = -STEP_Y;
      DIR_NEG:  delta_y = STEP_Y;
      DIR_HOLD: delta_y = '0;
      default:  delta_y = '0;
    endcase
    next_x = $signed({1'b0, pos_x}) + delta_x;
    next_y = $signed({1'b0, pos_y}) + delta_y;
    retire = next_x[X_W] || (next_x > LIM_X) || next_y[Y_W] || (next_y > LIM_Y);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      pos_x  <= '0;
      pos_y  <= '0;
      old_x  <= '0;
      old_y  <= '0;
      dir_x  <= DIR_HOLD;
      dir_y  <= DIR_HOLD;
    end else if (kill && active) begin
      active <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
      pos_x  <= load_x;
      pos_y  <= load_y;
      dir_x  <= load_dir_x;
      dir_y  <= load_dir_y;
    end else if (step && active) begin
      old_x <= pos_x;
      old_y <= pos_y;
      // a retiring bullet keeps its position so the erase beat hits the right pixel
      if (retire) begin
        active <= 1'b0;
      end else begin
        pos_x <= next_x[X_W-1:0];
        pos_y <= next_y[Y_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: allocates slots on fire, steps live bullets on each movement
// tick and then walks the slots emitting erase/draw pixel requests.
// Ports:
//   clk, resetn              clock, async active-low reset
//   fire, start_x/y, dir_x/y fire request with spawn position and heading
//   fire_accept              fire taken this cycle (a slot was free)
//   hit                      per-slot collision kill
//   active                   slot-live vector
//   plot_valid/ready         pixel request handshake
//   plot_x/y, plot_erase     pixel and colour select (1 = background)
//   plot_idx                 slot owning the request
//
// state    | meaning
// ST_IDLE  | waiting for a pending tick; steps all slots when it comes
// ST_SCAN  | decide whether slot idx was live before the step
// ST_ERASE | request background at old position
// ST_DRAW  | request bullet colour at new position
// ST_NEXT  | advance idx or return to idle after the last slot
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = SCREEN_X_MAX,
  parameter int Y_MAX       = SCREEN_Y_MAX,
  parameter int STEP        = 3,
  parameter int TICK_CYCLES = 12500000,
  localparam int IDX_W      = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   fire,
  input  logic [X_W-1:0]         start_x,
  input  logic [Y_W-1:0]         start_y,
  input  logic [1:0]             dir_x,
  input  logic [1:0]             dir_y,
  output logic                   fire_accept,
  input  logic [NUM_BULLETS-1:0] hit,
  output logic [NUM_BULLETS-1:0] active,
  output logic                   plot_valid,
  input  logic                   plot_ready,
  output logic [X_W-1:0]         plot_x,
  output logic [Y_W-1:0]         plot_y,
  output logic                   plot_erase,
  output logic [IDX_W-1:0]       plot_idx
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [X_W-1:0]         pos_x [NUM_BULLETS];
  logic [Y_W-1:0]         pos_y [NUM_BULLETS];
  logic [X_W-1:0]         old_x [NUM_BULLETS];
  logic [Y_W-1:0]         old_y [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] alloc, load, was_live;
  logic                   found, step_all, tick_pend;
  logic [CNT_W-1:0]       tick_cnt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  plot_state_t            state, state_nxt;

  // lowest-index free slot, one-hot
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!found && !active[i]) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign fire_accept = fire & ~&active;
  assign load        = fire_accept ? alloc : '0;
  assign step_all    = (state == ST_IDLE) && tick_pend;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_pool_slot #(
      .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP)
    ) u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .load       (load[g]),
      .step       (step_all),
      .kill       (hit[g]),
      .load_x     (start_x),
      .load_y     (start_y),
      .load_dir_x (dir_x),
      .load_dir_y (dir_y),
      .active     (active[g]),
      .pos_x      (pos_x[g]),
      .pos_y      (pos_y[g]),
      .old_x      (old_x[g]),
      .old_y      (old_y[g])
    );
  end

  // A new tick wins over consumption in the same cycle so it is never lost;
  // further ticks while one is pending simply merge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
    end else begin
      if (tick_cnt == '0) tick_cnt <= CNT_W'(TICK_CYCLES - 1);
      else                tick_cnt <= tick_cnt - 1'b1;
      if (tick_cnt == '0) tick_pend <= 1'b1;
      else if (step_all)  tick_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      idx      <= '0;
      was_live <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (step_all) was_live <= active;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (tick_pend) begin
          state_nxt = ST_SCAN;
          idx_nxt   = '0;
        end
      end
      ST_SCAN:  state_nxt = was_live[idx] ? ST_ERASE : ST_NEXT;
      ST_ERASE: if (plot_ready) state_nxt = active[idx] ? ST_DRAW : ST_NEXT;
      ST_DRAW:  if (plot_ready) state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (idx == IDX_W'(NUM_BULLETS - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_SCAN;
          idx_nxt   = idx + 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Coordinates are captured on entry to each beat so a reload of the slot
  // while the arbiter stalls cannot change a request already presented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot_x <= '0;
      plot_y <= '0;
    end else if (state == ST_SCAN && was_live[idx]) begin
      plot_x <= old_x[idx];
      plot_y <= old_y[idx];
    end else if (state == ST_ERASE && plot_ready && active[idx]) begin
      plot_x <= pos_x[idx];
      plot_y <= pos_y[idx];
    end
  end

  assign plot_valid = (state == ST_ERASE) || (state == ST_DRAW);
  assign plot_erase = (state == ST_ERASE) ? PLOT_COLOUR_BG : PLOT_COLOUR_BULLET;
  assign plot_idx   = idx;

endmodule
